// File: rtl/gcd_host_sequencer.sv
// rtl/gcd_host_sequencer.sv - operand-pair queue and sequencer driving an external GCD engine
module gcd_pair_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage array; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module gcd_host_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             out_err,
    output logic             gcd_rst_n,
    output logic             gcd_start,
    output logic [WIDTH-1:0] op_x,
    output logic [WIDTH-1:0] op_y,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             busy
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_PRESENT
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] fifo_head;
    logic [TW-1:0]      timer;
    logic               timed_out;
    logic               timer_max;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && !fifo_full;
    assign timer_max = (timer == TW'(TIMEOUT));
    assign out_valid = (state_q == S_PRESENT);
    assign busy      = (state_q != S_IDLE);

    gcd_pair_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({in_x, in_y}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and engine control decode; engine held in reset outside a run.
    always_comb begin
        state_d   = state_q;
        gcd_rst_n = 1'b0;
        gcd_start = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (op_x != '0 && op_y != '0) ? S_LAUNCH : S_CAPTURE;
            end
            S_LAUNCH: begin
                gcd_rst_n = 1'b1;
                gcd_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                gcd_rst_n = 1'b1;
                gcd_start = 1'b1;
                if (gcd_done || timer_max) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                gcd_rst_n = 1'b1;
                fifo_pop  = !fifo_empty;
                state_d   = S_PRESENT;
            end
            S_PRESENT: begin
                gcd_rst_n = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand latch, saturating wait timer and result capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_x      <= '0;
            op_y      <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
            out_gcd   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_x <= fifo_head[2*WIDTH-1:WIDTH];
                        op_y <= fifo_head[WIDTH-1:0];
                    end
                end
                S_CLEAR: begin
                    timed_out <= 1'b0;
                end
                S_LAUNCH: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    if (!timer_max) begin
                        timer <= timer + TW'(1);
                    end
                    if (!gcd_done && timer_max) begin
                        timed_out <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (op_x == '0 || op_y == '0) begin
                        out_gcd <= op_x | op_y;
                        out_err <= (op_x == '0) && (op_y == '0);
                    end else if (timed_out) begin
                        out_gcd <= '0;
                        out_err <= 1'b1;
                    end else begin
                        out_gcd <= gcd_result;
                        out_err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_host_sequencer.sv
// tb/tb_gcd_host_sequencer.sv - randomized self-checking bench for gcd_host_sequencer
module tb_gcd_host_sequencer;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TO = 1023;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         gcd_rst_n;
    logic         gcd_start;
    logic [W-1:0] op_x;
    logic [W-1:0] op_y;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];

    int   eng_lat  = 3;
    bit   eng_dead = 0;
    int   eng_cnt;
    int   start_cycles = 0;

    gcd_host_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gcd    (out_gcd),
        .out_err    (out_err),
        .gcd_rst_n  (gcd_rst_n),
        .gcd_start  (gcd_start),
        .op_x       (op_x),
        .op_y       (op_y),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .busy       (busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        int a, b, t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return W'(a);
    endfunction

    // {err, gcd} the sequencer must report for a pair when the engine answers
    function automatic logic [W:0] expect_of(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x == 0 && y == 0) return {1'b1, {W{1'b0}}};
        if (x == 0) return {1'b0, y};
        if (y == 0) return {1'b0, x};
        return {1'b0, gcd_ref(x, y)};
    endfunction

    // Engine model: after eng_lat enabled cycles, raise done and hold it until reset.
    always @(posedge clk) begin
        if (!gcd_rst_n) begin
            eng_cnt    <= 0;
            gcd_done   <= 1'b0;
            gcd_result <= '0;
        end else if (gcd_start && !gcd_done && !eng_dead) begin
            if (eng_cnt + 1 >= eng_lat) begin
                gcd_done   <= 1'b1;
                gcd_result <= gcd_ref(op_x, op_y);
            end
            eng_cnt <= eng_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (gcd_start === 1'b1) start_cycles <= start_cycles + 1;
    end

    task automatic push_pair(input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL push_wait in_ready=%b required=1", in_ready);
        end else begin
            exp_q.push_back(expect_of(x, y));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int stall);
        int n;
        logic [W:0] exp;
        out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL result_wait out_valid=%b required=1", out_valid);
            return;
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got=%h required=none", {out_err, out_gcd});
            return;
        end
        exp = exp_q.pop_front();
        if ({out_err, out_gcd} !== exp) begin
            errors++;
            $display("FAIL result err/gcd=%b/%0d required=%b/%0d", out_err, out_gcd, exp[W], exp[W-1:0]);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_err, out_gcd} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d valid/err/gcd=%b/%b/%0d required=1/%b/%0d",
                         i, out_valid, out_err, out_gcd, exp[W], exp[W-1:0]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse out_valid=%b required=0", out_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_err, gcd_start, gcd_rst_n, busy, out_gcd, op_x, op_y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs v/e/s/r/b=%b%b%b%b%b gcd=%0d opx=%0d opy=%0d required all 0",
                     out_valid, out_err, gcd_start, gcd_rst_n, busy, out_gcd, op_x, op_y);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset in_ready/busy=%b%b required=10", in_ready, busy);
        end
    endtask

    task automatic test_basic;
        int n;
        int s0;
        eng_lat = 3;
        s0 = start_cycles;
        push_pair(8'd12, 8'd18);
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({busy, gcd_rst_n, gcd_start, op_x, op_y} !== {3'b100, 8'd12, 8'd18}) begin
            errors++;
            $display("FAIL clear_phase busy/rst_n/start=%b%b%b op=%0d,%0d required=100 op=12,18",
                     busy, gcd_rst_n, gcd_start, op_x, op_y);
        end
        @(negedge clk);
        checks++;
        if ({gcd_rst_n, gcd_start, op_x, op_y} !== {2'b11, 8'd12, 8'd18}) begin
            errors++;
            $display("FAIL launch_phase rst_n/start=%b%b op=%0d,%0d required=11 op=12,18",
                     gcd_rst_n, gcd_start, op_x, op_y);
        end
        collect(0);
        checks++;
        if (start_cycles - s0 < 2) begin
            errors++;
            $display("FAIL start_cycles got=%0d required>=2", start_cycles - s0);
        end
    endtask

    task automatic test_bypass;
        int s0;
        s0 = start_cycles;
        push_pair(8'd0, 8'd7);
        collect(0);
        push_pair(8'd0, 8'd0);
        collect(0);
        push_pair(8'd45, 8'd0);
        collect(0);
        checks++;
        if (start_cycles != s0) begin
            errors++;
            $display("FAIL bypass_no_start start_cycles=%0d required=0", start_cycles - s0);
        end
    endtask

    task automatic test_timeout;
        int n;
        int starts;
        eng_dead = 1;
        push_pair(8'd9, 8'd6);
        void'(exp_q.pop_back());
        exp_q.push_back({1'b1, {W{1'b0}}});
        n = 0;
        starts = 0;
        while (out_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            if (gcd_start === 1'b1) starts++;
            n++;
        end
        checks++;
        if (starts < TO || starts > TO + 2) begin
            errors++;
            $display("FAIL timeout_length start_cycles=%0d required=%0d..%0d", starts, TO, TO + 2);
        end
        collect(0);
        eng_dead = 0;
        push_pair(8'd27, 8'd36);
        collect(0);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] xs[5];
        logic [W-1:0] ys[5];
        xs = '{8'd3, 8'd8, 8'd5, 8'd14, 8'd77};
        ys = '{8'd9, 8'd12, 8'd5, 8'd21, 8'd11};
        eng_lat = 20;
        out_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x = xs[i];
            in_y = ys[i];
            checks++;
            if (in_ready !== (i < 4)) begin
                errors++;
                $display("FAIL fill_ready offer %0d in_ready=%b required=%b", i, in_ready, (i < 4));
            end
            if (i < 4) exp_q.push_back(expect_of(xs[i], ys[i]));
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) collect(0);
        eng_lat = 3;
        checks++;
        if (exp_q.size() != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain left=%0d in_ready=%b required=0/1", exp_q.size(), in_ready);
        end
    endtask

    task automatic test_hold;
        push_pair(8'd100, 8'd75);
        collect(10);
    endtask

    task automatic test_random;
        int k;
        logic [W-1:0] x;
        logic [W-1:0] y;
        out_ready = 1'b0;
        for (int r = 0; r < 8; r++) begin
            eng_lat = $urandom_range(1, 6);
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                x = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                y = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                push_pair(x, y);
            end
            for (int j = 0; j < k; j++) collect($urandom_range(0, 3));
        end
        eng_lat = 3;
    endtask

    task automatic test_reset_mid;
        int n;
        bit seen;
        eng_dead = 1;
        out_ready = 1'b0;
        push_pair(8'd9, 8'd6);
        push_pair(8'd4, 8'd2);
        n = 0;
        while (gcd_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_err, gcd_start, gcd_rst_n, busy, out_gcd, op_x, op_y, in_ready} !== {{5 + 3 * W{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset v/e/s/r/b=%b%b%b%b%b gcd=%0d op=%0d,%0d in_ready=%b required 0s, in_ready=1",
                     out_valid, out_err, gcd_start, gcd_rst_n, busy, out_gcd, op_x, op_y, in_ready);
        end
        reset = 1'b1;
        exp_q.delete();
        eng_dead = 0;
        out_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL stale_after_reset activity=1 required=0");
        end
        push_pair(8'd12, 8'd8);
        collect(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_timeout();
        test_back_to_back();
        test_hold();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
